mem_line_master: RTL and testbench

//  Initiator side of the word-level memory handshake (rd/wr/address/datain/dataout/ready).

---
 rtl/mem_line_master.sv | 124 ++++++++++++
 tb/tb_mem_line_master.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/mem_line_master.sv
// rtl/mem_line_master.sv - word-by-word line fill/writeback initiator for the memory handshake
module mem_line_master #(
    parameter int DATA_WIDTH    = 16,
    parameter int ADR_WIDTH     = 16,
    parameter int OFFSET_WIDTH  = 2,
    parameter int TIMEOUT_WIDTH = 8
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 start,
    input  logic                                 wr_line,
    input  logic [ADR_WIDTH-OFFSET_WIDTH-1:0]    line_adr,
    input  logic [(DATA_WIDTH<<OFFSET_WIDTH)-1:0] wline,
    output logic [(DATA_WIDTH<<OFFSET_WIDTH)-1:0] rline,
    output logic                                 busy,
    output logic                                 done,
    output logic                                 err,
    output logic [ADR_WIDTH-1:0]                 mem_address,
    output logic [DATA_WIDTH-1:0]                mem_datain,
    input  logic [DATA_WIDTH-1:0]                mem_dataout,
    input  logic                                 mem_ready,
    output logic                                 mem_rd,
    output logic                                 mem_wr
);

    localparam int LINE_WIDTH = DATA_WIDTH << OFFSET_WIDTH;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        GAP    = 2'd2,
        FINISH = 2'd3
    } state_t;

    state_t                          state;
    logic [ADR_WIDTH-OFFSET_WIDTH-1:0] line_q;
    logic                            wr_q;
    logic [LINE_WIDTH-1:0]           wbuf;
    logic [OFFSET_WIDTH-1:0]         cnt;
    logic [TIMEOUT_WIDTH-1:0]        wd;

    // Address and write data come straight from latched registers, so they stay
    // stable for the whole ACCESS state and never leave the latched line.
    assign mem_address = {line_q, cnt};
    assign mem_datain  = wbuf[int'(cnt)*DATA_WIDTH +: DATA_WIDTH];

    // Transfer sequencer: one request per word, an idle GAP cycle between words,
    // watchdog per word, and all handshake/status outputs registered with the state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= IDLE;
            line_q <= '0;
            wr_q   <= 1'b0;
            wbuf   <= '0;
            cnt    <= '0;
            wd     <= '0;
            rline  <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            err    <= 1'b0;
            mem_rd <= 1'b0;
            mem_wr <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        line_q <= line_adr;
                        wr_q   <= wr_line;
                        wbuf   <= wline;
                        cnt    <= '0;
                        wd     <= '0;
                        err    <= 1'b0;
                        busy   <= 1'b1;
                        mem_rd <= ~wr_line;
                        mem_wr <= wr_line;
                        state  <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (mem_ready) begin
                        if (!wr_q) begin
                            rline[int'(cnt)*DATA_WIDTH +: DATA_WIDTH] <= mem_dataout;
                        end
                        mem_rd <= 1'b0;
                        mem_wr <= 1'b0;
                        if (cnt == '1) begin
                            done  <= 1'b1;
                            state <= FINISH;
                        end else begin
                            cnt   <= cnt + 1'b1;
                            state <= GAP;
                        end
                    end else begin
                        wd <= wd + 1'b1;
                        // A word that never completes abandons the rest of the line.
                        if (wd == '1) begin
                            err    <= 1'b1;
                            done   <= 1'b1;
                            mem_rd <= 1'b0;
                            mem_wr <= 1'b0;
                            state  <= FINISH;
                        end
                    end
                end
                GAP: begin
                    wd     <= '0;
                    mem_rd <= ~wr_q;
                    mem_wr <= wr_q;
                    state  <= ACCESS;
                end
                FINISH: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    cnt   <= '0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_line_master.sv
// tb/tb_mem_line_master.sv - directed table-driven bench for mem_line_master
module tb_mem_line_master;

    logic        clk;
    logic        rst;
    logic        start;
    logic        wr_line;
    logic [13:0] line_adr;
    logic [63:0] wline;
    logic [63:0] rline;
    logic        busy;
    logic        done;
    logic        err;
    logic [15:0] mem_address;
    logic [15:0] mem_datain;
    logic [15:0] mem_dataout;
    logic        mem_ready;
    logic        mem_rd;
    logic        mem_wr;

    int checks = 0;
    int errors = 0;

    mem_line_master #(
        .DATA_WIDTH(16), .ADR_WIDTH(16), .OFFSET_WIDTH(2), .TIMEOUT_WIDTH(8)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .wr_line(wr_line), .line_adr(line_adr),
        .wline(wline), .rline(rline), .busy(busy), .done(done), .err(err),
        .mem_address(mem_address), .mem_datain(mem_datain), .mem_dataout(mem_dataout),
        .mem_ready(mem_ready), .mem_rd(mem_rd), .mem_wr(mem_wr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model: completes a request in its 6th requested cycle
    logic [15:0] mem [0:1023];
    logic [2:0]  mcnt;
    logic        stall;
    logic        prev_ready;
    logic [15:0] addr_log [$];

    assign mem_ready   = (mem_rd | mem_wr) && (mcnt == 3'd5) && !stall;
    assign mem_dataout = mem_ready ? mem[mem_address[9:0]] : 16'hBAD0;

    always @(posedge clk) begin
        if (mem_rd | mem_wr) mcnt <= (mcnt == 3'd5) ? 3'd0 : mcnt + 3'd1;
        else                 mcnt <= 3'd0;
        prev_ready <= mem_ready;
        if (mem_ready) begin
            addr_log.push_back(mem_address);
            if (mem_wr) mem[mem_address[9:0]] <= mem_datain;
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Idle cycle after every completed word, and never read and write together
    always @(negedge clk) begin
        if (rst && prev_ready) check("gap_idle", {62'd0, mem_rd, mem_wr}, 64'd0);
        if (mem_rd | mem_wr)   check("rd_wr_excl", {63'd0, mem_rd & mem_wr}, 64'd0);
    end

    task automatic run_xfer(input bit wr, input logic [13:0] adr, input logic [63:0] wl,
                            output int cycles, output bit got_done);
        @(negedge clk);
        addr_log.delete();
        start = 1'b1; wr_line = wr; line_adr = adr; wline = wl;
        @(negedge clk);
        start = 1'b0;
        cycles = 1;
        got_done = 1'b0;
        check("busy_cycle1", {63'd0, busy}, 64'd1);
        check("err_clear_at_start", {63'd0, err}, 64'd0);
        while (cycles < 400) begin
            if (done) begin
                got_done = 1'b1;
                break;
            end
            @(negedge clk);
            cycles++;
        end
        check("done_seen", {63'd0, got_done}, 64'd1);
    endtask

    typedef struct {
        bit          wr;
        bit          stl;
        logic [13:0] adr;
        logic [63:0] wl;
        logic [63:0] exp_rline;
        int          exp_cycles;
        bit          exp_err;
    } vec_t;

    vec_t vecs [8];

    initial begin
        int          cyc;
        bit          gd;
        int          n_done;
        logic [15:0] a;

        vecs[0] = '{1'b0, 1'b0, 14'h0010, 64'h0, 64'hA003_A002_A001_A000, 28, 1'b0};
        vecs[1] = '{1'b1, 1'b0, 14'h0011, 64'h4444_3333_2222_1111, 64'hA003_A002_A001_A000, 28, 1'b0};
        vecs[2] = '{1'b1, 1'b0, 14'h0012, 64'hDEAD_BEEF_0F0F_F0F0, 64'hA003_A002_A001_A000, 28, 1'b0};
        vecs[3] = '{1'b0, 1'b0, 14'h0012, 64'h0, 64'hDEAD_BEEF_0F0F_F0F0, 28, 1'b0};
        vecs[4] = '{1'b0, 1'b0, 14'h0011, 64'h0, 64'h4444_3333_2222_1111, 28, 1'b0};
        vecs[5] = '{1'b0, 1'b0, 14'h3FFF, 64'h0, 64'h5553_5552_5551_5550, 28, 1'b0};
        vecs[6] = '{1'b0, 1'b1, 14'h0020, 64'h0, 64'h5553_5552_5551_5550, 257, 1'b1};
        vecs[7] = '{1'b0, 1'b0, 14'h0010, 64'h0, 64'hA003_A002_A001_A000, 28, 1'b0};

        for (int i = 0; i < 1024; i++) mem[i] <= 16'h0000;
        for (int i = 0; i < 4; i++) begin
            mem[10'h040 + i] <= 16'hA000 + 16'(i);
            mem[10'h3FC + i] <= 16'h5550 + 16'(i);
        end

        start = 1'b0; wr_line = 1'b0; line_adr = '0; wline = '0; stall = 1'b0;
        rst = 1'b1;
        #3 rst = 1'b0;
        #1;
        check("reset_ctrl", {58'd0, busy, done, err, mem_rd, mem_wr, 1'b0}, 64'd0);
        check("reset_addr", {32'd0, mem_address, mem_datain}, 64'd0);
        check("reset_rline", rline, 64'd0);
        repeat (3) @(negedge clk);
        rst = 1'b1;

        // Table: back-to-back transfers, start re-raised the cycle after done
        for (int i = 0; i < 8; i++) begin
            stall = vecs[i].stl;
            run_xfer(vecs[i].wr, vecs[i].adr, vecs[i].wl, cyc, gd);
            check($sformatf("v%0d_cycles", i), 64'(cyc), 64'(vecs[i].exp_cycles));
            check($sformatf("v%0d_err", i), {63'd0, err}, {63'd0, vecs[i].exp_err});
            check($sformatf("v%0d_req_low_at_done", i), {62'd0, mem_rd, mem_wr}, 64'd0);
            check($sformatf("v%0d_rline", i), rline, vecs[i].exp_rline);
            check($sformatf("v%0d_nwords", i), 64'(addr_log.size()), vecs[i].stl ? 64'd0 : 64'd4);
            for (int k = 0; k < 4 && k < addr_log.size(); k++)
                check($sformatf("v%0d_addr%0d", i, k), {48'd0, addr_log[k]}, {48'd0, vecs[i].adr, 2'(k)});
            if (vecs[i].wr) begin
                for (int k = 0; k < 4; k++) begin
                    a = {vecs[i].adr, 2'(k)};
                    check($sformatf("v%0d_mem%0d", i, k), {48'd0, mem[a[9:0]]},
                          {48'd0, vecs[i].wl[k*16 +: 16]});
                end
            end
            stall = 1'b0;
        end

        // Reset during word 2 of a fill aborts with no done
        @(negedge clk);
        addr_log.delete();
        start = 1'b1; wr_line = 1'b0; line_adr = 14'h0012;
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < 100 && addr_log.size() < 2; k++) @(negedge clk);
        check("rst_reach_word2", 64'(addr_log.size()), 64'd2);
        repeat (3) @(negedge clk);
        #1 rst = 1'b0;
        #1;
        check("abort_ctrl", {58'd0, busy, done, err, mem_rd, mem_wr, 1'b0}, 64'd0);
        check("abort_addr", {32'd0, mem_address, mem_datain}, 64'd0);
        check("abort_rline", rline, 64'd0);
        n_done = 0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (done) n_done++;
        end
        check("abort_no_done", 64'(n_done), 64'd0);
        rst = 1'b1;
        run_xfer(1'b0, 14'h0010, 64'h0, cyc, gd);
        check("post_rst_cycles", 64'(cyc), 64'd28);
        check("post_rst_rline", rline, 64'hA003_A002_A001_A000);

        // Start pulses while busy are dropped, not queued
        @(negedge clk);
        addr_log.delete();
        start = 1'b1; wr_line = 1'b0; line_adr = 14'h0011;
        @(negedge clk);
        n_done = 0;
        for (int c = 1; c < 60; c++) begin
            if (c == 3 || c == 10 || c == 20) begin
                start = 1'b1; wr_line = 1'b1; line_adr = 14'h0033;
            end else begin
                start = 1'b0;
            end
            if (done) n_done++;
            @(negedge clk);
        end
        start = 1'b0;
        check("busy_start_one_done", 64'(n_done), 64'd1);
        check("busy_start_nwords", 64'(addr_log.size()), 64'd4);
        for (int k = 0; k < 4 && k < addr_log.size(); k++)
            check($sformatf("busy_start_addr%0d", k), {48'd0, addr_log[k]}, {48'd0, 14'h0011, 2'(k)});
        check("busy_start_rline", rline, 64'h4444_3333_2222_1111);
        check("busy_start_idle", {63'd0, busy}, 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
